// File: rtl/alu_v33_pkg.sv
// Shared opcode encodings, flag-register bit positions and FSM state type
// for the v33 iterative execute-path ALU.
package alu_v33_pkg;

  localparam logic [5:0] OP_SHL = 6'h10;
  localparam logic [5:0] OP_SHR = 6'h11;
  localparam logic [5:0] OP_AND = 6'h12;
  localparam logic [5:0] OP_OR  = 6'h13;
  localparam logic [5:0] OP_XOR = 6'h14;
  localparam logic [5:0] OP_NOT = 6'h15;
  localparam logic [5:0] OP_CMP = 6'h16;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h21;
  localparam logic [5:0] OP_MUL = 6'h22;
  localparam logic [5:0] OP_DIV = 6'h23;
  localparam logic [5:0] OP_MOD = 6'h24;
  localparam logic [5:0] OP_INC = 6'h25;
  localparam logic [5:0] OP_DEC = 6'h26;

  localparam int FR_GT = 0;
  localparam int FR_LT = 1;
  localparam int FR_EQ = 2;
  localparam int FR_Z  = 3;
  localparam int FR_C  = 4;
  localparam int FR_OV = 5;
  localparam int FR_DZ = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared iterative engine: shift-add multiply or restoring divide over a
// {hi, lo} shift register, one bit per clock, DATA_W iterations per op.
module alu_iter_muldiv
  import alu_v33_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              rdy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CW = $clog2(DATA_W);

  logic [CW-1:0]     cnt;
  logic              run, div_q, src_div;
  logic [DATA_W-1:0] m_q, src_hi, src_lo, src_m, nxt_hi, nxt_lo;
  logic [DATA_W:0]   sum, shifted, diff;

  // Iteration 0 is computed from the live operands on the go edge, so the
  // last iteration (cnt == DATA_W-1) completes DATA_W-1 clocks later; rdy
  // flags that final iteration.
  assign rdy = run && (cnt == CW'(DATA_W - 1));

  always_comb begin
    src_div = go ? is_div : div_q;
    src_hi  = go ? '0 : hi;
    src_lo  = go ? (is_div ? a : b) : lo;
    src_m   = go ? (is_div ? b : a) : m_q;
    sum     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_m} : '0);
    shifted = {src_hi, src_lo[DATA_W-1]};
    diff    = shifted - {1'b0, src_m};
    if (src_div) begin
      nxt_hi = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
      nxt_lo = {src_lo[DATA_W-2:0], ~diff[DATA_W]};
    end else begin
      nxt_hi = sum[DATA_W:1];
      nxt_lo = {sum[0], src_lo[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
      run   <= 1'b0;
    end else if (go) begin
      hi    <= nxt_hi;
      lo    <= nxt_lo;
      m_q   <= src_m;
      div_q <= is_div;
      cnt   <= CW'(1);
      run   <= 1'b1;
    end else if (run) begin
      hi <= nxt_hi;
      lo <= nxt_lo;
      if (rdy) begin
        run <= 1'b0;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_iter_v33.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus iterative
// MUL/DIV/MOD through a shared engine, with registered result and flags.
module alu_iter_v33
  import alu_v33_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 16
) (
  input  logic              wire_clock,
  input  logic              wire_reset,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] opnd_a,
  input  logic [DATA_W-1:0] opnd_b,
  input  logic              use_carry,
  input  logic [FLAG_W-1:0] fr_in,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] fr_out,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fsm_state
);
  // Handshake: start is taken only while busy=0 (FSM idle); busy covers every
  // cycle after acceptance until done; done is a one-cycle pulse and the
  // registered result/fr_out are valid from that cycle until the next done.
  localparam int M = DATA_W - 1;
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              wr, set_z, go, go_div, rdy, mul_q, mod_q, ci, is_sub;
  logic [DATA_W-1:0] res_d, opb, hi, lo;
  logic [FLAG_W-1:0] fr_d, fr_q;
  logic [DATA_W:0]   wide;

  alu_iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
    .clk    (wire_clock),
    .rst_n  (wire_reset),
    .go     (go),
    .is_div (go_div),
    .a      (opnd_a),
    .b      (opnd_b),
    .rdy    (rdy),
    .hi     (hi),
    .lo     (lo)
  );

  assign busy      = (state_q != S_IDLE);
  assign fsm_state = state_q;

  // One DATA_W+1 adder serves ADD/SUB/INC/DEC; INC/DEC ignore the FR carry.
  always_comb begin
    is_sub = (opcode == OP_SUB) || (opcode == OP_DEC);
    opb    = ((opcode == OP_INC) || (opcode == OP_DEC)) ? ONE : opnd_b;
    ci     = ((opcode == OP_ADD) || (opcode == OP_SUB)) && use_carry && fr_in[FR_C];
    if (is_sub) wide = {1'b0, opnd_a} - {1'b0, opb} - {{DATA_W{1'b0}}, ci};
    else        wide = {1'b0, opnd_a} + {1'b0, opb} + {{DATA_W{1'b0}}, ci};
  end

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    set_z   = 1'b0;
    go      = 1'b0;
    go_div  = 1'b0;
    res_d   = '0;
    fr_d    = fr_in;
    case (state_q)
      S_IDLE: if (start) begin
        wr    = 1'b1;
        set_z = 1'b1;
        case (opcode)
          OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
            res_d        = wide[M:0];
            fr_d[FR_C]   = wide[DATA_W];
            fr_d[FR_OV]  = (opnd_a[M] ^ opb[M] ^ ~is_sub) & (opnd_a[M] ^ wide[M]);
          end
          OP_AND: res_d = opnd_a & opnd_b;
          OP_OR:  res_d = opnd_a | opnd_b;
          OP_XOR: res_d = opnd_a ^ opnd_b;
          OP_NOT: res_d = ~opnd_a;
          OP_SHL: begin
            res_d      = {opnd_a[M-1:0], 1'b0};
            fr_d[FR_C] = opnd_a[M];
          end
          OP_SHR: begin
            res_d      = {1'b0, opnd_a[M:1]};
            fr_d[FR_C] = opnd_a[0];
          end
          OP_CMP: begin
            res_d       = result;
            set_z       = 1'b0;
            fr_d[FR_GT] = (opnd_a > opnd_b);
            fr_d[FR_LT] = (opnd_a < opnd_b);
            fr_d[FR_EQ] = (opnd_a == opnd_b);
          end
          OP_MUL: begin
            wr      = 1'b0;
            go      = 1'b1;
            state_d = S_MUL;
          end
          OP_DIV, OP_MOD: begin
            if (opnd_b == '0) begin
              fr_d[FR_DZ] = 1'b1;
            end else begin
              wr      = 1'b0;
              go      = 1'b1;
              go_div  = 1'b1;
              state_d = S_DIV;
            end
          end
          default: set_z = 1'b0;
        endcase
      end
      S_MUL, S_DIV: if (rdy) state_d = S_FIN;
      S_FIN: begin
        wr      = 1'b1;
        set_z   = 1'b1;
        fr_d    = fr_q;
        state_d = S_IDLE;
        if (mul_q) begin
          res_d       = lo;
          fr_d[FR_OV] = |hi;
        end else begin
          res_d       = mod_q ? hi : lo;
          fr_d[FR_DZ] = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (set_z) fr_d[FR_Z] = (res_d == '0);
  end

  always_ff @(posedge wire_clock or negedge wire_reset) begin
    if (!wire_reset) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_ff @(posedge wire_clock or negedge wire_reset) begin
    if (!wire_reset) begin
      result <= '0;
      fr_out <= '0;
      done   <= 1'b0;
      mul_q  <= 1'b0;
      mod_q  <= 1'b0;
      fr_q   <= '0;
    end else begin
      done <= wr;
      if (wr) begin
        result <= res_d;
        fr_out <= fr_d;
      end
      if (go) begin
        mul_q <= ~go_div;
        mod_q <= (opcode == OP_MOD);
        fr_q  <= fr_in;
      end
    end
  end

endmodule

// File: tb/tb_alu_iter_v33.sv
// Self-checking bench for alu_iter_v33 (DATA_W=16): directed cases plus
// randomized ops scored against an arithmetic reference model.
module tb_alu_iter_v33;
  import alu_v33_pkg::*;

  localparam int W = 16;
  localparam int F = 16;
  localparam logic [5:0] OP_TAB [15] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
    OP_INC, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_CMP, 6'h3F};

  logic         wire_clock = 1'b0;
  logic         wire_reset = 1'b0;
  logic         start = 1'b0;
  logic         use_carry = 1'b0;
  logic [5:0]   opcode = '0;
  logic [W-1:0] opnd_a = '0;
  logic [W-1:0] opnd_b = '0;
  logic [F-1:0] fr_in = '0;
  logic [W-1:0] result;
  logic [F-1:0] fr_out;
  logic         busy, done;
  logic [1:0]   fsm_state;

  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];
  logic [F-1:0] exp_fr_q[$];
  int           exp_lat_q[$];
  logic [W-1:0] last_res = '0;

  alu_iter_v33 #(.DATA_W(W), .FLAG_W(F)) dut (
    .wire_clock (wire_clock),
    .wire_reset (wire_reset),
    .start      (start),
    .opcode     (opcode),
    .opnd_a     (opnd_a),
    .opnd_b     (opnd_b),
    .use_carry  (use_carry),
    .fr_in      (fr_in),
    .result     (result),
    .fr_out     (fr_out),
    .busy       (busy),
    .done       (done),
    .fsm_state  (fsm_state)
  );

  always #5 wire_clock = ~wire_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the architectural rules.
  function automatic void model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic uc, input logic [F-1:0] fi, input logic [W-1:0] prev,
                                output logic [W-1:0] r, output logic [F-1:0] fo, output int lat);
    longint ua, ub, sa, sb, t, s, ci;
    bit z_ok;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = (uc && fi[FR_C]) ? 1 : 0;
    fo = fi;
    r = '0;
    lat = 1;
    z_ok = 1'b1;
    if (op == OP_INC || op == OP_DEC) begin
      ub = 1;
      sb = 1;
      ci = 0;
    end
    case (op)
      OP_ADD, OP_INC: begin
        t = ua + ub + ci;
        s = sa + sb + ci;
        r = t[W-1:0];
        fo[FR_C] = (t > 65535);
        fo[FR_OV] = (s > 32767 || s < -32768);
      end
      OP_SUB, OP_DEC: begin
        t = ua - ub - ci;
        s = sa - sb - ci;
        r = t[W-1:0];
        fo[FR_C] = (t < 0);
        fo[FR_OV] = (s > 32767 || s < -32768);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: begin
        t = ua * 2;
        r = t[W-1:0];
        fo[FR_C] = (ua >= 32768);
      end
      OP_SHR: begin
        t = ua / 2;
        r = t[W-1:0];
        fo[FR_C] = (ua % 2 == 1);
      end
      OP_MUL: begin
        t = ua * ub;
        r = t[W-1:0];
        fo[FR_OV] = (t > 65535);
        lat = 17;
      end
      OP_DIV, OP_MOD: begin
        if (ub == 0) begin
          fo[FR_DZ] = 1'b1;
        end else begin
          t = (op == OP_DIV) ? ua / ub : ua % ub;
          r = t[W-1:0];
          fo[FR_DZ] = 1'b0;
          lat = 17;
        end
      end
      OP_CMP: begin
        r = prev;
        z_ok = 1'b0;
        fo[FR_GT] = (ua > ub);
        fo[FR_LT] = (ua < ub);
        fo[FR_EQ] = (ua == ub);
      end
      default: z_ok = 1'b0;
    endcase
    if (z_ok) fo[FR_Z] = (r == '0);
  endfunction

  // Drive an issue request at the current (negedge) time and queue the expectation.
  task automatic send(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic uc, input logic [F-1:0] fi);
    logic [W-1:0] r;
    logic [F-1:0] fo;
    int lat;
    model(op, a, b, uc, fi, last_res, r, fo, lat);
    last_res = r;
    exp_q.push_back(r);
    exp_fr_q.push_back(fo);
    exp_lat_q.push_back(lat);
    opcode = op;
    opnd_a = a;
    opnd_b = b;
    use_carry = uc;
    fr_in = fi;
    start = 1'b1;
  endtask

  // Wait (bounded) for done, then score latency, busy window, result and flags.
  task automatic collect(input string tag, input bit poke);
    int cycles, busy_cyc, extra, el;
    logic [W-1:0] er;
    logic [F-1:0] ef;
    busy_cyc = 0;
    extra = 0;
    @(negedge wire_clock);
    start = 1'b0;
    opcode = 6'($urandom);
    opnd_a = W'($urandom);
    opnd_b = W'($urandom);
    use_carry = 1'($urandom_range(0, 1));
    cycles = 1;
    while (!done && cycles < 40) begin
      if (busy) busy_cyc++;
      start = poke && (cycles == 5);
      if (start) opcode = OP_ADD;
      opnd_a = W'($urandom);
      @(negedge wire_clock);
      cycles++;
    end
    start = 1'b0;
    el = exp_lat_q.pop_front();
    er = exp_q.pop_front();
    ef = exp_fr_q.pop_front();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, cycles, el);
    check({tag, "_busy_cycles"}, busy_cyc, el - 1);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_flags"}, 32'(fr_out), 32'(ef));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (poke) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge wire_clock);
        if (done) extra++;
      end
      check({tag, "_no_extra_done"}, extra, 0);
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge wire_clock);
    check("rst_result", 32'(result), 32'd0);
    check("rst_fr_out", 32'(fr_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(S_IDLE));
    wire_reset = 1'b1;

    @(negedge wire_clock); send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, '0);   collect("add_wrap", 1'b0);
    @(negedge wire_clock); send(OP_MUL, 16'h0100, 16'h0100, 1'b0, '0);   collect("mul_ovf", 1'b0);
    @(negedge wire_clock); send(OP_MUL, 16'd300, 16'd200, 1'b0, 16'h0020); collect("mul_300x200", 1'b0);
    @(negedge wire_clock); send(OP_DIV, 16'd1000, 16'd7, 1'b0, '0);      collect("div_1000_7", 1'b0);
    @(negedge wire_clock); send(OP_MOD, 16'd1000, 16'd7, 1'b0, '0);      collect("mod_1000_7", 1'b0);
    @(negedge wire_clock); send(OP_DIV, 16'd5, 16'd0, 1'b0, '0);         collect("div_by_zero", 1'b0);
    @(negedge wire_clock); send(OP_SUB, 16'd5, 16'd9, 1'b1, 16'h0010);   collect("sub_borrow", 1'b0);
    @(negedge wire_clock); send(OP_MUL, 16'd1234, 16'd56, 1'b0, '0);     collect("mul_poke", 1'b1);
    @(negedge wire_clock); send(OP_ADD, 16'd40, 16'd2, 1'b0, '0);        collect("add_42", 1'b0);
    send(OP_CMP, 16'd3, 16'd9, 1'b0, '0);                                collect("cmp_b2b", 1'b0);

    // Abort a division part-way through with an asynchronous reset.
    @(negedge wire_clock); send(OP_DIV, 16'd1000, 16'd7, 1'b0, '0);
    @(negedge wire_clock); start = 1'b0;
    repeat (8) @(negedge wire_clock);
    wire_reset = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'd0);
    check("abort_fr_out", 32'(fr_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_state", 32'(fsm_state), 32'(S_IDLE));
    exp_q.delete();
    exp_fr_q.delete();
    exp_lat_q.delete();
    last_res = '0;
    @(negedge wire_clock); wire_reset = 1'b1;
    @(negedge wire_clock); send(OP_SUB, 16'd5, 16'd3, 1'b0, '0);         collect("sub_after_rst", 1'b0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1) @(negedge wire_clock);
      op = OP_TAB[$urandom_range(0, 14)];
      ra = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : (($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 300)) : W'($urandom));
      send(op, ra, rb, 1'($urandom_range(0, 1)), F'($urandom));
      collect("rand", 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_iter_v33.md
Name: alu_iter_v33

Overview:
- Parametrised successor of the v32 execute path: a DATA_W-wide ALU with a start/busy/done handshake.
- Single-cycle logic and arithmetic ops are retained.
- Iterative multi-cycle MUL/DIV/MOD engines are added; the v32 combinational ALU does not have these.
- Sits between the control unit (issues op, operands, incoming FR) and the register file/FR (consumes result and outgoing flags).

Parameters:
- DATA_W, 16: operand/result width; legal values 8..32.
- FLAG_W, 16: width of the flag register (FR) bus.

Ports:
- wire_clock  in  1  system clock, rising edge.
- wire_reset  in  1  asynchronous, active-low reset.
- start  in  1  issue request; sampled only when busy=0.
- opcode  in  6  operation select (encodings in package).
- opnd_a  in  DATA_W  first operand.
- opnd_b  in  DATA_W  second operand.
- use_carry  in  1  ADD/SUB include FR carry bit.
- fr_in  in  FLAG_W  current flag register.
- result  out  DATA_W  registered result; held until next done.
- fr_out  out  FLAG_W  registered updated flags.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result/fr_out valid from this cycle.

Behaviour:
- Reset (wire_reset=0, asynchronous): result=0, fr_out=0, busy=0, done=0, FSM=IDLE, iteration counter=0, partial registers=0. Reset mid-operation aborts the op with no done pulse.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE + start + single-cycle op: compute, register result/flags → done=1 next cycle (latency 1), stay IDLE.
  - IDLE + start + MUL: latch operands → MUL.
  - IDLE + start + DIV/MOD with opnd_b≠0: latch operands → DIV.
  - MUL and DIV each run exactly DATA_W iterations (counter 0..DATA_W-1), then → FIN.
  - FIN: register result/flags, done=1, → IDLE.
  - MUL/DIV/MOD latency: DATA_W+1 cycles from the start edge to done (17 at DATA_W=16).
- start while busy=1 is ignored; operands are latched at accept, so later input changes have no effect.
- Back-to-back: start may be asserted in the same cycle done=1; it is accepted because the FSM is already IDLE.
- Single-cycle ops: ADD, SUB, INC, DEC, AND, OR, XOR, NOT, SHL, SHR, CMP.
- ADD/SUB: width DATA_W+1 internally. Carry-in = fr_in[FR_C] when use_carry=1.
  - ADD: carry = bit DATA_W.
  - SUB: carry = borrow.
  - Overflow flag set on signed overflow.
- CMP: result unchanged (holds previous value); sets greater/lesser/equal (unsigned compare).
- MUL: unsigned shift-add over a 2*DATA_W accumulator. result = low half; FR_OV=1 if high half ≠0.
- DIV/MOD: unsigned restoring division. DIV → quotient; MOD → remainder.
- Divide by zero: latency 1, result=0, FR_DZ=1, no iteration.
- Flags: fr_out = fr_in with only the bits affected by the op rewritten; all other bits pass through.
  - FR_Z: set iff result==0, for every op except CMP.
- Undefined opcode: latency 1, result=0, fr_out=fr_in.

Decomposition:
- Package alu_v33_pkg holds:
  - opcode constants: OP_ADD=6'h20, OP_SUB=6'h21, OP_MUL=6'h22, OP_DIV=6'h23, OP_MOD=6'h24, OP_INC=6'h25, OP_DEC=6'h26, OP_AND=6'h12, OP_OR=6'h13, OP_XOR=6'h14, OP_NOT=6'h15, OP_SHL=6'h10, OP_SHR=6'h11, OP_CMP=6'h16;
  - flag indices: FR_GT=0, FR_LT=1, FR_EQ=2, FR_Z=3, FR_C=4, FR_OV=5, FR_DZ=6;
  - FSM state encoding.
- One sub-module, alu_iter_muldiv: holds the shared shift register and counter for MUL/DIV. Its interface is go, is_div, a, b → rdy, hi, lo.

Test Plan (DATA_W=16):
- ADD 16'hFFFF + 16'h0001, use_carry=0 → done next cycle; result=0, FR_C=1, FR_Z=1.
- MUL 16'h0100 × 16'h0100 → busy for 16 cycles, done at cycle 17; result=0, FR_OV=1. Also MUL 300×200 → result=60000, FR_OV=0.
- DIV 1000/7 → quotient 142 in 17 cycles. MOD 1000/7 → result=6. DIV 5/0 → done after 1 cycle, result=0, FR_DZ=1.
- During MUL: pulse start with OP_ADD and change opnd_a mid-operation → ignored; MUL result is unaffected; no extra done.
- Assert wire_reset=0 at iteration 8 of DIV → result/fr_out/busy/done=0 immediately. After release, SUB 5-3 → result=2, done after 1 cycle.
- CMP 3 vs 9 with result previously 42 → FR_LT=1, FR_GT=0, FR_EQ=0, result still 42. Back-to-back start on the done cycle is accepted.
